rdm_bit_deinterleaver: RTL and testbench

//  NR TS38.212 5.4.2.2 bit de-interleaver; sits directly downstream of the 6-bit LLR packing FIFO.

---
 rtl/rdm_bit_deinterleaver.sv | 199 +++++++++++++++++++
 tb/tb_rdm_bit_deinterleaver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rdm_bit_deinterleaver.sv
// rdm_bit_deinterleaver: bit de-interleaver that scatters each Qm-wide LLR pop
// into per-row address ranges (row i base = i*E/Qm) of the de-interleave RAM.
module rdm_bit_deinterleaver #(
    parameter int LANES = 16,
    parameter int LLR_W = 6,
    parameter int AW    = 16
) (
    input  logic                   i_core_clk,
    input  logic                   i_rx_rstn,
    input  logic                   cfg_start,
    input  logic [3:0]             cfg_qm,
    input  logic [15:0]            cfg_e,
    output logic                   PopPermit,
    output logic [3:0]             PopAmout,
    input  logic                   PopEnable,
    input  logic [LANES*LLR_W-1:0] PopData,
    output logic                   wr_en,
    output logic [LANES-1:0]       wr_lane_vld,
    output logic [LANES*AW-1:0]    wr_addr,
    output logic [LANES*LLR_W-1:0] wr_data,
    input  logic                   wr_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err_cfg
);

    typedef enum logic [2:0] {
        S_IDLE, S_DIV, S_BASE, S_RUN, S_DRAIN, S_DONE, S_ERR
    } state_e;

    state_e state_q, state_d;

    logic [3:0]    qm_q;
    logic [3:0]    cnt_q;
    logic [3:0]    rem_q;
    logic [15:0]   quo_q;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] base_q [LANES];
    logic [15:0]   col_q;

    logic                   wr_en_q, wr_en_d;
    logic [LANES-1:0]       vld_q, vld_d;
    logic [LANES*AW-1:0]    addr_q, addr_d;
    logic [LANES*LLR_W-1:0] data_q, data_d;

    logic [4:0]  qm_n;
    logic [4:0]  shl;
    logic [4:0]  diff;
    logic        ge;
    logic [3:0]  rem_nx;
    logic [15:0] quo_nx;
    logic        qm_ok;
    logic        cfg_bad;
    logic        permit;
    logic        pop;
    logic        acc_wr;
    logic        last_col;

    // One restoring-division step; the quotient shifts in where E shifts out.
    assign qm_n   = {1'b0, qm_q} + 5'd1;
    assign shl    = {rem_q, quo_q[15]};
    assign ge     = shl >= qm_n;
    assign diff   = shl - qm_n;
    assign rem_nx = ge ? diff[3:0] : shl[3:0];
    assign quo_nx = {quo_q[14:0], ge};

    always_comb begin
        qm_ok = 1'b0;
        case (qm_q)
            4'd0, 4'd1, 4'd3, 4'd5, 4'd7, 4'd9: qm_ok = 1'b1;
            default:                            qm_ok = 1'b0;
        endcase
    end

    // A zero quotient with zero remainder can only come from E == 0.
    assign cfg_bad  = !qm_ok || (rem_nx != 4'd0) || (quo_nx == 16'd0);
    assign permit   = (state_q == S_RUN) && (col_q < quo_q)
                      && (!wr_en_q || wr_ready);
    assign pop      = PopEnable && permit;
    assign acc_wr   = wr_en_q && wr_ready;
    assign last_col = (col_q == quo_q - 16'd1);

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (cfg_start) state_d = S_DIV;
            S_DIV:   if (cnt_q == 4'd15) state_d = cfg_bad ? S_ERR : S_BASE;
            S_BASE:  if (cnt_q == qm_q) state_d = S_RUN;
            S_RUN:   if (pop && last_col) state_d = S_DRAIN;
            S_DRAIN: if (acc_wr) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PopPermit = permit;
        busy      = (state_q == S_DIV) || (state_q == S_BASE)
                    || (state_q == S_RUN) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
        err_cfg   = (state_q == S_ERR);
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            qm_q  <= '0;
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            acc_q <= '0;
            col_q <= '0;
            for (int i = 0; i < LANES; i++) base_q[i] <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        qm_q  <= cfg_qm;
                        quo_q <= cfg_e;
                        rem_q <= '0;
                        cnt_q <= '0;
                        acc_q <= '0;
                        col_q <= '0;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q + 4'd1;
                end
                S_BASE: begin
                    base_q[cnt_q] <= acc_q;
                    acc_q         <= acc_q + AW'(quo_q);
                    cnt_q         <= cnt_q + 4'd1;
                end
                S_RUN: begin
                    if (pop) col_q <= col_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Output register: load on pop, hold while stalled, clear once drained.
    always_comb begin
        wr_en_d = wr_en_q;
        vld_d   = vld_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop) begin
            wr_en_d = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                if (i <= int'(qm_q)) begin
                    vld_d[i]                  = 1'b1;
                    addr_d[AW*i +: AW]        = base_q[i] + AW'(col_q);
                    data_d[LLR_W*i +: LLR_W]  = PopData[LLR_W*i +: LLR_W];
                end else begin
                    vld_d[i]                  = 1'b0;
                    addr_d[AW*i +: AW]        = '0;
                    data_d[LLR_W*i +: LLR_W]  = '0;
                end
            end
        end else if (acc_wr) begin
            wr_en_d = 1'b0;
            vld_d   = '0;
            addr_d  = '0;
            data_d  = '0;
        end
    end

    always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
        if (!i_rx_rstn) begin
            wr_en_q <= 1'b0;
            vld_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            vld_q   <= vld_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign PopAmout    = qm_q;
    assign wr_en       = wr_en_q;
    assign wr_lane_vld = vld_q;
    assign wr_addr     = addr_q;
    assign wr_data     = data_q;

endmodule

// File: tb/tb_rdm_bit_deinterleaver.sv
// Bench for rdm_bit_deinterleaver: table of codeblock configs streamed with
// continuous pops, plus stall, error and mid-run reset sequences.
module tb_rdm_bit_deinterleaver;

    localparam int LANES = 16;
    localparam int LLR_W = 6;
    localparam int AW    = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cfg_start = 1'b0;
    logic [3:0]             cfg_qm = '0;
    logic [15:0]            cfg_e = '0;
    logic                   PopPermit;
    logic [3:0]             PopAmout;
    logic                   PopEnable = 1'b0;
    logic [LANES*LLR_W-1:0] PopData = '0;
    logic                   wr_en;
    logic [LANES-1:0]       wr_lane_vld;
    logic [LANES*AW-1:0]    wr_addr;
    logic [LANES*LLR_W-1:0] wr_data;
    logic                   wr_ready = 1'b1;
    logic                   busy;
    logic                   done;
    logic                   err_cfg;

    rdm_bit_deinterleaver #(.LANES(LANES), .LLR_W(LLR_W), .AW(AW)) dut (
        .i_core_clk (clk),
        .i_rx_rstn  (rst_n),
        .cfg_start  (cfg_start),
        .cfg_qm     (cfg_qm),
        .cfg_e      (cfg_e),
        .PopPermit  (PopPermit),
        .PopAmout   (PopAmout),
        .PopEnable  (PopEnable),
        .PopData    (PopData),
        .wr_en      (wr_en),
        .wr_lane_vld(wr_lane_vld),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done),
        .err_cfg    (err_cfg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int qm;
        int e;
        bit err;
        int eq;
        int stall_w;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] mk(input int j, input int qm);
        logic [95:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++)
            d[6*i +: 6] = (i < qm) ? 6'(j*16 + i + 1) : 6'h3f;
        return d;
    endfunction

    function automatic logic [95:0] exp_data(input int w, input int qm);
        logic [95:0] d;
        d = '0;
        for (int i = 0; i < qm; i++) d[6*i +: 6] = 6'(w*16 + i + 1);
        return d;
    endfunction

    function automatic logic [255:0] exp_addr(input int w, input int qm,
                                              input int eq);
        logic [255:0] a;
        a = '0;
        for (int i = 0; i < qm; i++) a[16*i +: 16] = 16'(i*eq + w);
        return a;
    endfunction

    task automatic chk_idle(input string p);
        chk({p, "_wr_en"}, wr_en, 0);
        chk({p, "_vld"}, wr_lane_vld, 0);
        chk({p, "_addr"}, wr_addr, 0);
        chk({p, "_data"}, wr_data, 0);
        chk({p, "_permit"}, PopPermit, 0);
        chk({p, "_amout"}, PopAmout, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_err"}, err_cfg, 0);
    endtask

    task automatic run_cb(input vec_t v, input bit bogus);
        int n;
        int w;
        int j;
        int stl;
        int wrc;
        bit fin;
        bit acc;
        bit popped;
        logic [3:0] qm1;
        qm1 = 4'(v.qm - 1);
        cfg_qm = qm1;
        cfg_e = 16'(v.e);
        cfg_start = 1'b1;
        PopEnable = 1'b0;
        wr_ready = 1'b1;
        tick();
        cfg_start = 1'b0;
        n = 1;
        chk("busy_start", busy, 1);
        while (n < 40 && !PopPermit && !err_cfg) begin
            if (bogus && n == 17) begin
                cfg_start = 1'b1;
                cfg_qm = 4'd0;
                cfg_e = 16'd1;
            end
            tick();
            cfg_start = 1'b0;
            cfg_qm = qm1;
            cfg_e = 16'(v.e);
            n++;
        end
        if (v.err) begin
            chk("err_lat", n, 17);
            chk("err_pulse", err_cfg, 1);
            chk("err_permit", PopPermit, 0);
            chk("err_busy", busy, 0);
            tick();
            chk("err_clear", err_cfg, 0);
            chk("err_busy_after", busy, 0);
            chk("err_permit_after", PopPermit, 0);
            return;
        end
        chk("pp_lat", n, 17 + v.qm);
        chk("amout", PopAmout, qm1);
        w = 0;
        j = 0;
        stl = 0;
        wrc = 0;
        fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            wr_ready = 1'b1;
            if (wr_en && w == v.stall_w && stl < 3) begin
                wr_ready = 1'b0;
                stl++;
            end
            #1;
            if (wr_en) begin
                wrc++;
                chk("wr_in_range", w < v.eq, 1);
                chk("wr_vld", wr_lane_vld, 16'((1 << v.qm) - 1));
                chk("wr_addr", wr_addr, exp_addr(w, v.qm, v.eq));
                chk("wr_data", wr_data, exp_data(w, v.qm));
            end
            if (wr_en && !wr_ready) chk("pp_stall", PopPermit, 0);
            if (j >= v.eq) chk("pp_after_last", PopPermit, 0);
            PopEnable = (j < v.eq);
            PopData = mk(j, v.qm);
            popped = PopEnable && PopPermit;
            acc = wr_en && wr_ready;
            tick();
            if (popped) j++;
            if (acc) w++;
            chk("done", done, acc && w == v.eq);
            if (acc && w == v.eq) begin
                chk("busy_at_done", busy, 0);
                fin = 1'b1;
            end
        end
        PopEnable = 1'b0;
        chk("stream_timeout", fin, 1);
        chk("writes", w, v.eq);
        chk("pops", j, v.eq);
        chk("wr_cycles", wrc, v.eq + stl);
        tick();
        chk("done_clear", done, 0);
        chk("busy_after", busy, 0);
        chk("wr_en_after", wr_en, 0);
    endtask

    initial begin
        vec_t v6;
        tbl[0] = '{qm: 4,  e: 12, err: 0, eq: 3, stall_w: 99};
        tbl[1] = '{qm: 2,  e: 8,  err: 0, eq: 4, stall_w: 2};
        tbl[2] = '{qm: 4,  e: 10, err: 1, eq: 0, stall_w: 99};
        tbl[3] = '{qm: 3,  e: 9,  err: 1, eq: 0, stall_w: 99};
        tbl[4] = '{qm: 1,  e: 1,  err: 0, eq: 1, stall_w: 99};
        tbl[5] = '{qm: 10, e: 40, err: 0, eq: 4, stall_w: 99};
        tbl[6] = '{qm: 6,  e: 12, err: 0, eq: 2, stall_w: 0};
        tbl[7] = '{qm: 2,  e: 0,  err: 1, eq: 0, stall_w: 99};
        tbl[8] = '{qm: 8,  e: 16, err: 0, eq: 2, stall_w: 99};

        tick();
        tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 9; k++) run_cb(tbl[k], 1'b0);

        cfg_qm = 4'd1;
        cfg_e = 16'd8;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int n = 0; n < 40 && !PopPermit; n++) tick();
        chk("t6_run", PopPermit, 1);
        PopEnable = 1'b1;
        PopData = mk(0, 2);
        tick();
        PopData = mk(1, 2);
        tick();
        PopEnable = 1'b0;
        chk("t6_wr_pre", wr_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle("t6_rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("t6_post");
        v6 = '{qm: 2, e: 8, err: 0, eq: 4, stall_w: 99};
        run_cb(v6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
